axi_burst_shim: RTL and testbench

AXI_BURST_SHIM -- requirements
Module: axi_burst_shim

---
 rtl/axi_burst_shim.sv | 279 +++++++++++++++++++++++++++
 tb/tb_axi_burst_shim.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_shim.sv
// axi_burst_shim: turns a cache-line write/read request interface into AXI bursts.
// Writes issue AW and W together and track both handshakes independently. The requester
// gets one grant pulse once AW and the last W beat have both been accepted.
// Reads and write responses are combinational pass-throughs with no buffering.
// Optional feature: define AXI_BURST_SHIM_WR_LIMIT_EN to cap granted-but-unacknowledged
// writes at MaxWrOutstanding. New writes stall in idle while the cap is reached.

package ariane_axi;
    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned UserWidth = 1;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [5:0]           atop;
        logic [UserWidth-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic                   last;
        logic [UserWidth-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [UserWidth-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

module axi_burst_shim #(
    parameter int unsigned AxiAddrWidth     = 64,
    parameter int unsigned AxiDataWidth     = 64,
    parameter int unsigned AxiNumWords      = 4,
    parameter int unsigned AxiIdWidth       = 4,
    parameter int unsigned MaxWrOutstanding = 4,
    parameter type         axi_req_t        = ariane_axi::req_t,
    parameter type         axi_resp_t       = ariane_axi::resp_t,
    localparam int unsigned BW = (AxiNumWords > 1) ? $clog2(AxiNumWords) : 1
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    // write request
    input  logic                                         wr_req_i,
    output logic                                         wr_gnt_o,
    input  logic [AxiAddrWidth-1:0]                      wr_addr_i,
    input  logic [AxiNumWords-1:0][AxiDataWidth-1:0]     wr_data_i,
    input  logic [AxiNumWords-1:0][AxiDataWidth/8-1:0]   wr_be_i,
    input  logic [BW-1:0]                                wr_blen_i,
    input  logic [2:0]                                   wr_size_i,
    input  logic [AxiIdWidth-1:0]                        wr_id_i,
    input  logic                                         wr_lock_i,
    input  logic [5:0]                                   wr_atop_i,
    // write response
    input  logic                                         wr_rdy_i,
    output logic                                         wr_valid_o,
    output logic [AxiIdWidth-1:0]                        wr_id_o,
    output logic                                         wr_exokay_o,
    // read
    input  logic                                         rd_req_i,
    output logic                                         rd_gnt_o,
    input  logic [AxiAddrWidth-1:0]                      rd_addr_i,
    input  logic [BW-1:0]                                rd_blen_i,
    input  logic [2:0]                                   rd_size_i,
    input  logic [AxiIdWidth-1:0]                        rd_id_i,
    input  logic                                         rd_lock_i,
    input  logic                                         rd_instr_i,
    input  logic                                         rd_rdy_i,
    output logic                                         rd_valid_o,
    output logic                                         rd_last_o,
    output logic                                         rd_exokay_o,
    output logic [AxiDataWidth-1:0]                      rd_data_o,
    output logic [AxiIdWidth-1:0]                        rd_id_o,
    // AXI master port
    output axi_req_t                                     axi_req_o,
    input  axi_resp_t                                    axi_resp_i
);

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] RespExOkay = 2'b01;

    // StWOnly: AW accepted, W beats remain. StAwOnly: last W accepted, AW remains.
    typedef enum logic [1:0] {StIdle, StBusy, StWOnly, StAwOnly} wr_state_e;

    wr_state_e     state_q, state_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic          aw_valid, w_valid, w_last, gnt, stall;
    logic          aw_done, w_done;

    assign w_last = (cnt_q == wr_blen_i);

`ifdef AXI_BURST_SHIM_WR_LIMIT_EN
    localparam int unsigned OutW = $clog2(MaxWrOutstanding + 1);

    logic [OutW-1:0] out_q, out_d;
    logic            b_hs;

    assign b_hs  = axi_resp_i.b_valid & wr_rdy_i;
    assign stall = (out_q == OutW'(MaxWrOutstanding));

    // Outstanding count: grant adds, B handshake removes, never below zero
    always_comb begin
        out_d = out_q;
        if (gnt && !b_hs) begin
            out_d = out_q + 1'b1;
        end else if (!gnt && b_hs && (out_q != '0)) begin
            out_d = out_q - 1'b1;
        end
    end

    // Outstanding counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end
`else
    assign stall = 1'b0;
`endif

    // Write FSM next state, channel valids, grant and beat counter
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        gnt      = 1'b0;

        unique case (state_q)
            // Reset gating keeps both valids low while rst_ni is held, even with a live request
            StIdle: begin
                if (wr_req_i && !stall && rst_ni) begin
                    aw_valid = 1'b1;
                    w_valid  = 1'b1;
                end
            end
            StBusy: begin
                aw_valid = 1'b1;
                w_valid  = 1'b1;
            end
            StWOnly:  w_valid  = 1'b1;
            StAwOnly: aw_valid = 1'b1;
        endcase

        aw_done = (aw_valid & axi_resp_i.aw_ready) | (state_q == StWOnly);
        w_done  = (w_valid & axi_resp_i.w_ready & w_last) | (state_q == StAwOnly);

        if (aw_valid || w_valid) begin
            if (aw_done && w_done) begin
                gnt     = 1'b1;
                state_d = StIdle;
            end else if (aw_done) begin
                state_d = StWOnly;
            end else if (w_done) begin
                state_d = StAwOnly;
            end else begin
                state_d = StBusy;
            end
        end

        if (w_valid && axi_resp_i.w_ready) begin
            cnt_d = w_last ? '0 : cnt_q + 1'b1;
        end
    end

    // Write FSM and beat counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wr_gnt_o = gnt;

    // AXI request assembly; unused attributes (cache, qos, region, user) stay zero
    always_comb begin
        axi_req_o          = '0;
        axi_req_o.aw.id    = wr_id_i;
        axi_req_o.aw.addr  = wr_addr_i;
        axi_req_o.aw.len   = 8'(wr_blen_i);
        axi_req_o.aw.size  = wr_size_i;
        axi_req_o.aw.burst = (wr_blen_i == '0) ? BurstFixed : BurstIncr;
        axi_req_o.aw.lock  = wr_lock_i;
        axi_req_o.aw.atop  = wr_atop_i;
        axi_req_o.aw_valid = aw_valid;
        axi_req_o.w.data   = wr_data_i[cnt_q];
        axi_req_o.w.strb   = wr_be_i[cnt_q];
        axi_req_o.w.last   = w_last;
        axi_req_o.w_valid  = w_valid;
        axi_req_o.b_ready  = wr_rdy_i;
        axi_req_o.ar.id    = rd_id_i;
        axi_req_o.ar.addr  = rd_addr_i;
        axi_req_o.ar.len   = 8'(rd_blen_i);
        axi_req_o.ar.size  = rd_size_i;
        axi_req_o.ar.burst = (rd_blen_i == '0) ? BurstFixed : BurstIncr;
        axi_req_o.ar.lock  = rd_lock_i;
        axi_req_o.ar.prot  = {rd_instr_i, 2'b00};
        axi_req_o.ar_valid = rd_req_i;
        axi_req_o.r_ready  = rd_rdy_i;
    end

    assign wr_valid_o  = axi_resp_i.b_valid;
    assign wr_id_o     = axi_resp_i.b.id;
    assign wr_exokay_o = (axi_resp_i.b.resp == RespExOkay);

    assign rd_gnt_o    = rd_req_i & axi_resp_i.ar_ready;
    assign rd_valid_o  = axi_resp_i.r_valid;
    assign rd_last_o   = axi_resp_i.r.last;
    assign rd_data_o   = axi_resp_i.r.data;
    assign rd_id_o     = axi_resp_i.r.id;
    assign rd_exokay_o = (axi_resp_i.r.resp == RespExOkay);

    // User fields and the limit parameter are intentionally not consumed in every build
    logic unused_cfg;
    assign unused_cfg = ^{axi_resp_i.b.user, axi_resp_i.r.user, (MaxWrOutstanding == 0)};

endmodule

// File: tb/tb_axi_burst_shim.sv
// Bench for axi_burst_shim: pass-through vector table, W-beat scoreboard, multi-cycle
// write sequences, reset mid-burst and an outstanding-limit sequence table.
`timescale 1ns/1ps
module tb_axi_burst_shim;
    localparam int unsigned NW = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned BW = 2;

`ifdef AXI_BURST_SHIM_WR_LIMIT_EN
    localparam bit LimEn = 1'b1;
`else
    localparam bit LimEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic                      wr_req, wr_gnt, wr_lock, wr_rdy, wr_valid, wr_exokay;
    logic [63:0]               wr_addr, rd_addr, rd_data;
    logic [NW-1:0][DW-1:0]     wr_data;
    logic [NW-1:0][DW/8-1:0]   wr_be;
    logic [BW-1:0]             wr_blen, rd_blen;
    logic [2:0]                wr_size, rd_size;
    logic [3:0]                wr_id, wr_id_out, rd_id, rd_id_out;
    logic [5:0]                wr_atop;
    logic                      rd_req, rd_gnt, rd_lock, rd_instr, rd_rdy;
    logic                      rd_valid, rd_last, rd_exokay;
    ariane_axi::req_t          req;
    ariane_axi::resp_t         resp;

    axi_burst_shim #(
        .AxiAddrWidth    (64),
        .AxiDataWidth    (DW),
        .AxiNumWords     (NW),
        .AxiIdWidth      (4),
        .MaxWrOutstanding(2)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .wr_req_i   (wr_req),
        .wr_gnt_o   (wr_gnt),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .wr_be_i    (wr_be),
        .wr_blen_i  (wr_blen),
        .wr_size_i  (wr_size),
        .wr_id_i    (wr_id),
        .wr_lock_i  (wr_lock),
        .wr_atop_i  (wr_atop),
        .wr_rdy_i   (wr_rdy),
        .wr_valid_o (wr_valid),
        .wr_id_o    (wr_id_out),
        .wr_exokay_o(wr_exokay),
        .rd_req_i   (rd_req),
        .rd_gnt_o   (rd_gnt),
        .rd_addr_i  (rd_addr),
        .rd_blen_i  (rd_blen),
        .rd_size_i  (rd_size),
        .rd_id_i    (rd_id),
        .rd_lock_i  (rd_lock),
        .rd_instr_i (rd_instr),
        .rd_rdy_i   (rd_rdy),
        .rd_valid_o (rd_valid),
        .rd_last_o  (rd_last),
        .rd_exokay_o(rd_exokay),
        .rd_data_o  (rd_data),
        .rd_id_o    (rd_id_out),
        .axi_req_o  (req),
        .axi_resp_i (resp)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } beat_t;

    beat_t w_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive a new write's payload and push the beats it should produce
    task automatic setup_write(input int blen, input logic [63:0] base);
        beat_t b;
        logic [7:0] be0;
        be0 = 8'h11;
        wr_blen = BW'(blen);
        for (int k = 0; k < NW; k++) begin
            wr_data[k] = base + 64'(k) * 64'h0101;
            wr_be[k]   = be0 << k;
        end
        for (int k = 0; k <= blen; k++) begin
            b.data = wr_data[k];
            b.strb = wr_be[k];
            b.last = (k == blen);
            w_q.push_back(b);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        wr_req = 1'b0;
        wr_rdy = 1'b0;
        resp   = '0;
        w_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // W-beat monitor: every accepted beat must match the next expected one
    always @(negedge clk) begin
        beat_t e;
        #2;
        if (rst_n && req.w_valid && resp.w_ready) begin
            if (w_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL w_beat: got unexpected beat %h, expected none", req.w.data);
            end else begin
                e = w_q.pop_front();
                chk("w_data", req.w.data, e.data);
                chk("w_strb", 64'(req.w.strb), 64'(e.strb));
                chk("w_last", 64'(req.w.last), 64'(e.last));
            end
        end
    end

    typedef struct {
        logic        b_valid;
        logic [3:0]  b_id;
        logic [1:0]  b_resp;
        logic        wr_rdy;
        logic        r_valid;
        logic [63:0] r_data;
        logic        r_last;
        logic [1:0]  r_resp;
        logic [3:0]  r_id;
        logic        rd_rdy;
        logic        rd_req;
        logic        ar_ready;
        logic [1:0]  rd_blen;
        logic        rd_instr;
        logic        e_wr_exokay;
        logic        e_rd_exokay;
        logic        e_rd_gnt;
        logic [1:0]  e_burst;
        logic [2:0]  e_prot;
    } vec_t;

    typedef struct {
        logic wr_req;
        logic b_valid;
        logic e_gnt_lim;
    } seq_t;

    vec_t vt[4];
    seq_t st[21];

    initial begin
        logic prev_gnt;
        logic e_gnt;

        wr_req = 0; wr_addr = '0; wr_data = '0; wr_be = '0; wr_blen = '0; wr_size = '0;
        wr_id = '0; wr_lock = 0; wr_atop = '0; wr_rdy = 0;
        rd_req = 0; rd_addr = '0; rd_blen = '0; rd_size = '0; rd_id = '0; rd_lock = 0;
        rd_instr = 0; rd_rdy = 0; resp = '0;

        //           bv  bid    bresp  wrdy rv  rdata                  rl  rresp  rid    rrdy rq  ar  blen  ins exw exr gnt burst  prot
        vt[0] = '{1'b1, 4'h3, 2'b00, 1'b1, 1'b1, 64'h1111_2222_3333_4444, 1'b0, 2'b01, 4'h5, 1'b1,
                  1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 3'b100};
        vt[1] = '{1'b1, 4'h9, 2'b01, 1'b0, 1'b0, 64'hDEAD_BEEF_0000_0001, 1'b1, 2'b10, 4'h2, 1'b0,
                  1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 3'b000};
        vt[2] = '{1'b0, 4'h0, 2'b11, 1'b1, 1'b1, 64'h0F0F_0F0F_F0F0_F0F0, 1'b1, 2'b11, 4'hF, 1'b1,
                  1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 3'b100};
        vt[3] = '{1'b1, 4'hC, 2'b10, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 2'b00, 4'h8, 1'b0,
                  1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'b000};

        st[0]  = '{1, 0, 1}; st[1]  = '{1, 0, 1}; st[2]  = '{1, 0, 0}; st[3]  = '{1, 0, 0};
        st[4]  = '{1, 1, 0}; st[5]  = '{1, 0, 1}; st[6]  = '{0, 1, 0}; st[7]  = '{1, 1, 1};
        st[8]  = '{1, 0, 1}; st[9]  = '{1, 0, 0}; st[10] = '{1, 1, 0}; st[11] = '{1, 0, 1};
        st[12] = '{0, 1, 0}; st[13] = '{0, 1, 0}; st[14] = '{0, 1, 0}; st[15] = '{1, 0, 1};
        st[16] = '{1, 0, 1}; st[17] = '{1, 0, 0}; st[18] = '{1, 1, 0}; st[19] = '{1, 0, 1};
        st[20] = '{0, 0, 0};

        // Reset: valids and grant stay low even with a request pending
        #2 rst_n = 1'b0;
        @(negedge clk);
        wr_req = 1'b1;
        resp.aw_ready = 1'b1;
        resp.w_ready  = 1'b1;
        #1;
        chk("rst_aw_valid", req.aw_valid, 0);
        chk("rst_w_valid", req.w_valid, 0);
        chk("rst_gnt", wr_gnt, 0);
        wr_req = 1'b0;
        resp   = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Pass-through vectors (no write in flight)
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            resp.b_valid  = vt[i].b_valid;
            resp.b.id     = vt[i].b_id;
            resp.b.resp   = vt[i].b_resp;
            wr_rdy        = vt[i].wr_rdy;
            resp.r_valid  = vt[i].r_valid;
            resp.r.data   = vt[i].r_data;
            resp.r.last   = vt[i].r_last;
            resp.r.resp   = vt[i].r_resp;
            resp.r.id     = vt[i].r_id;
            rd_rdy        = vt[i].rd_rdy;
            rd_req        = vt[i].rd_req;
            resp.ar_ready = vt[i].ar_ready;
            rd_blen       = vt[i].rd_blen;
            rd_instr      = vt[i].rd_instr;
            rd_addr       = 64'hC000_0000 + 64'(i) * 64'h40;
            rd_id         = 4'(i + 7);
            rd_size       = 3'(i);
            rd_lock       = i[0];
            #1;
            chk("tv_wr_valid", wr_valid, vt[i].b_valid);
            chk("tv_wr_id", wr_id_out, vt[i].b_id);
            chk("tv_wr_exokay", wr_exokay, vt[i].e_wr_exokay);
            chk("tv_b_ready", req.b_ready, vt[i].wr_rdy);
            chk("tv_rd_valid", rd_valid, vt[i].r_valid);
            chk("tv_rd_data", rd_data, vt[i].r_data);
            chk("tv_rd_last", rd_last, vt[i].r_last);
            chk("tv_rd_exokay", rd_exokay, vt[i].e_rd_exokay);
            chk("tv_rd_id", rd_id_out, vt[i].r_id);
            chk("tv_r_ready", req.r_ready, vt[i].rd_rdy);
            chk("tv_rd_gnt", rd_gnt, vt[i].e_rd_gnt);
            chk("tv_ar_valid", req.ar_valid, vt[i].rd_req);
            chk("tv_ar_burst", req.ar.burst, vt[i].e_burst);
            chk("tv_ar_prot", req.ar.prot, vt[i].e_prot);
            chk("tv_ar_len", req.ar.len, 64'(vt[i].rd_blen));
            chk("tv_ar_addr", req.ar.addr, 64'hC000_0000 + 64'(i) * 64'h40);
            chk("tv_ar_id", req.ar.id, 64'(i + 7));
            chk("tv_ar_size", req.ar.size, 64'(i));
            chk("tv_ar_lock", req.ar.lock, 64'(i % 2));
            chk("tv_ar_attr0", {req.ar.cache, req.ar.qos, req.ar.region}, 0);
            chk("tv_aw_valid_idle", req.aw_valid, 0);
        end
        rd_req = 0;
        rd_rdy = 0;

        // Single-beat write, both ready: grant in the same cycle
        do_reset();
        @(negedge clk);
        setup_write(0, 64'h1000);
        wr_addr = 64'h8000_0040; wr_size = 3'd3; wr_id = 4'h6; wr_lock = 1'b1; wr_atop = 6'h21;
        resp.aw_ready = 1'b1;
        resp.w_ready  = 1'b1;
        wr_req = 1'b1;
        #1;
        chk("s1_aw_valid", req.aw_valid, 1);
        chk("s1_w_valid", req.w_valid, 1);
        chk("s1_gnt", wr_gnt, 1);
        chk("s1_burst", req.aw.burst, 2'b00);
        chk("s1_len", req.aw.len, 0);
        chk("s1_addr", req.aw.addr, 64'h8000_0040);
        chk("s1_id", req.aw.id, 4'h6);
        chk("s1_size", req.aw.size, 3'd3);
        chk("s1_lock", req.aw.lock, 1);
        chk("s1_atop", req.aw.atop, 6'h21);
        chk("s1_attr0", {req.aw.cache, req.aw.prot, req.aw.qos, req.aw.region}, 0);
        chk("s1_w_last", req.w.last, 1);
        @(negedge clk);
        wr_req = 1'b0;
        #1;
        chk("s1_idle_awv", req.aw_valid, 0);
        chk("s1_idle_gnt", wr_gnt, 0);

        // 4-beat write, AW held off until cycle 5, W always ready
        do_reset();
        wr_lock = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                setup_write(3, 64'h2000);
                wr_req = 1'b1;
                resp.w_ready = 1'b1;
            end
            resp.aw_ready = (c == 5);
            #1;
            chk("b4a_aw_valid", req.aw_valid, 1);
            chk("b4a_w_valid", req.w_valid, 64'(c <= 3));
            chk("b4a_burst", req.aw.burst, 2'b01);
            chk("b4a_len", req.aw.len, 3);
            chk("b4a_gnt", wr_gnt, 64'(c == 5));
        end
        @(negedge clk);
        wr_req = 1'b0;
        resp.aw_ready = 1'b0;
        #1;
        chk("b4a_idle_wv", req.w_valid, 0);
        chk("b4a_idle_awv", req.aw_valid, 0);

        // 4-beat write, AW at cycle 0, W ready toggling
        do_reset();
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c == 0) begin
                setup_write(3, 64'h3000);
                wr_req = 1'b1;
            end
            resp.aw_ready = (c == 0);
            resp.w_ready  = (c % 2 == 0);
            #1;
            chk("b4b_aw_valid", req.aw_valid, 64'(c == 0));
            chk("b4b_w_valid", req.w_valid, 1);
            chk("b4b_gnt", wr_gnt, 64'(c == 6));
        end
        // Beat counter is back at word 0: a single-beat write sends data[0] as last
        @(negedge clk);
        setup_write(0, 64'h4000);
        resp.aw_ready = 1'b1;
        resp.w_ready  = 1'b1;
        #1;
        chk("b4b_next_last", req.w.last, 1);
        chk("b4b_next_gnt", wr_gnt, 1);
        @(negedge clk);
        wr_req = 1'b0;

        // Reset during beat 2 of a 4-beat write abandons it without a grant
        do_reset();
        for (int c = 0; c <= 2; c++) begin
            @(negedge clk);
            if (c == 0) begin
                setup_write(3, 64'h5000);
                wr_req = 1'b1;
            end
            resp.aw_ready = 1'b0;
            resp.w_ready  = 1'b1;
            if (c == 2) begin
                rst_n = 1'b0;
                w_q.delete();
            end
            #1;
            chk("rm_aw_valid", req.aw_valid, 64'(c < 2));
            chk("rm_w_valid", req.w_valid, 64'(c < 2));
            chk("rm_gnt", wr_gnt, 0);
        end
        @(negedge clk);
        wr_req = 1'b0;
        #1;
        chk("rm_hold_gnt", wr_gnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        setup_write(0, 64'h6000);
        wr_req = 1'b1;
        resp.aw_ready = 1'b0;
        resp.w_ready  = 1'b0;
        #1;
        chk("rm_new_awv", req.aw_valid, 1);
        chk("rm_new_wv", req.w_valid, 1);
        chk("rm_new_last", req.w.last, 1);
        chk("rm_new_gnt0", wr_gnt, 0);
        @(negedge clk);
        resp.aw_ready = 1'b1;
        resp.w_ready  = 1'b1;
        #1;
        chk("rm_new_gnt1", wr_gnt, 1);
        @(negedge clk);
        wr_req = 1'b0;

        // Back-to-back single writes against the outstanding limit (2 when enabled)
        do_reset();
        prev_gnt = 1'b0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            if (st[i].wr_req && (!wr_req || prev_gnt)) begin
                setup_write(0, 64'hA000 + 64'(i) * 64'h10000);
            end
            wr_req        = st[i].wr_req;
            wr_rdy        = 1'b1;
            resp.b_valid  = st[i].b_valid;
            resp.b.id     = 4'(i);
            resp.aw_ready = 1'b1;
            resp.w_ready  = 1'b1;
            e_gnt = LimEn ? st[i].e_gnt_lim : st[i].wr_req;
            #1;
            chk($sformatf("lim_gnt[%0d]", i), wr_gnt, 64'(e_gnt));
            chk($sformatf("lim_awv[%0d]", i), req.aw_valid, 64'(e_gnt));
            chk($sformatf("lim_wv[%0d]", i), req.w_valid, 64'(e_gnt));
            prev_gnt = wr_gnt;
        end
        @(negedge clk);
        wr_req = 1'b0;
        resp   = '0;
        @(negedge clk);
        #3;
        chk("wq_empty", 64'(w_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the bench always ends
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
